// File: rtl/dram_arbiter.sv
// dram_arbiter: two-port arbiter/sequencer in front of the single-port data RAM.
// Port 0 is the core LSU and port 1 is DMA/debug. Each port owns a one-entry
// response slot, so a stalled consumer never loses load data and never blocks
// the other port.
module dram_arbiter #(
    parameter int XLEN       = 32,
    parameter int LINES      = 64,
    parameter int FIXED_PRIO = 0
) (
    input  logic                 i_clk,
    input  logic                 i_rst,
    input  logic [1:0]           i_req_valid,
    output logic [1:0]           o_req_ready,
    input  logic [1:0]           i_req_we,
    input  logic [1:0][XLEN-1:0] i_req_addr,
    input  logic [1:0][XLEN-1:0] i_req_wdata,
    output logic [1:0]           o_rsp_valid,
    input  logic [1:0]           i_rsp_ready,
    output logic [1:0][XLEN-1:0] o_rsp_rdata,
    output logic [1:0]           o_rsp_err,
    output logic [XLEN-1:0]      o_mem_addr,
    output logic                 o_mem_load,
    output logic                 o_mem_store,
    output logic [XLEN-1:0]      o_mem_wdata,
    input  logic [XLEN-1:0]      i_mem_rdata
);

    localparam logic [1:0] S_FREE = 2'd0;
    localparam logic [1:0] S_INFL = 2'd1;
    localparam logic [1:0] S_HELD = 2'd2;
    localparam logic [XLEN-1:0] LINES_W = XLEN'(LINES);

    logic [1:0][1:0]      r_slot;
    logic [1:0][1:0]      w_slot_nxt;
    logic [1:0]           r_infl_err;
    logic [1:0][XLEN-1:0] r_hold_data;
    logic [1:0]           r_hold_err;
    logic                 r_last;       // port granted most recently
    logic [1:0]           w_elig;
    logic [1:0]           w_gnt;
    logic                 w_sel;
    logic                 w_inrange;
    logic [1:0]           w_ld_gnt;

    // Eligibility and single-winner grant; gated off while reset is held
    always_comb begin
        w_gnt = 2'b00;
        for (int p = 0; p < 2; p++) begin
            w_elig[p] = i_req_valid[p] &
                        (i_req_we[p] | (r_slot[p] == S_FREE) |
                         ((r_slot[p] != S_FREE) & i_rsp_ready[p]));
        end
        if (i_rst) begin
            if (FIXED_PRIO != 0) begin
                if (w_elig[0])      w_gnt = 2'b01;
                else if (w_elig[1]) w_gnt = 2'b10;
            end else if (&w_elig) begin
                // the port that did not win last time goes first
                w_gnt = r_last ? 2'b01 : 2'b10;
            end else begin
                w_gnt = w_elig;
            end
        end
        w_sel     = w_gnt[1];
        w_inrange = i_req_addr[w_sel] < LINES_W;
        w_ld_gnt  = w_gnt & ~i_req_we;
    end

    // RAM command: one access per cycle, nothing for out-of-range addresses
    always_comb begin
        o_req_ready = w_gnt;
        o_mem_addr  = '0;
        o_mem_load  = 1'b0;
        o_mem_store = 1'b0;
        o_mem_wdata = '0;
        if ((|w_gnt) && w_inrange) begin
            o_mem_addr = i_req_addr[w_sel];
            if (i_req_we[w_sel]) begin
                o_mem_store = 1'b1;
                o_mem_wdata = i_req_wdata[w_sel];
            end else begin
                o_mem_load = 1'b1;
            end
        end
    end

    // Slot state register
    always_ff @(posedge i_clk) begin
        if (!i_rst) r_slot <= {S_FREE, S_FREE};
        else        r_slot <= w_slot_nxt;
    end

    // Slot next-state: a new load always wins, otherwise drain or hold
    always_comb begin
        for (int p = 0; p < 2; p++) begin
            case (r_slot[p])
                S_INFL:  w_slot_nxt[p] = i_rsp_ready[p] ? S_FREE : S_HELD;
                S_HELD:  w_slot_nxt[p] = i_rsp_ready[p] ? S_FREE : S_HELD;
                default: w_slot_nxt[p] = S_FREE;
            endcase
            if (w_ld_gnt[p]) w_slot_nxt[p] = S_INFL;
        end
    end

    // Slot outputs: live RAM data while in flight, hold register afterwards
    always_comb begin
        for (int p = 0; p < 2; p++) begin
            o_rsp_valid[p] = 1'b0;
            o_rsp_rdata[p] = '0;
            o_rsp_err[p]   = 1'b0;
            case (r_slot[p])
                S_INFL: begin
                    o_rsp_valid[p] = 1'b1;
                    o_rsp_err[p]   = r_infl_err[p];
                    o_rsp_rdata[p] = r_infl_err[p] ? '0 : i_mem_rdata;
                end
                S_HELD: begin
                    o_rsp_valid[p] = 1'b1;
                    o_rsp_err[p]   = r_hold_err[p];
                    o_rsp_rdata[p] = r_hold_data[p];
                end
                default: ;
            endcase
        end
    end

    // Error tag for the load in flight and capture of unconsumed data
    always_ff @(posedge i_clk) begin
        if (!i_rst) begin
            r_infl_err  <= '0;
            r_hold_data <= '0;
            r_hold_err  <= '0;
        end else begin
            for (int p = 0; p < 2; p++) begin
                if (w_ld_gnt[p]) r_infl_err[p] <= ~w_inrange;
                if (r_slot[p] == S_INFL && !i_rsp_ready[p]) begin
                    r_hold_data[p] <= o_rsp_rdata[p];
                    r_hold_err[p]  <= o_rsp_err[p];
                end
            end
        end
    end

    // Round-robin pointer; reset value makes port 0 win the first tie
    always_ff @(posedge i_clk) begin
        if (!i_rst)      r_last <= 1'b1;
        else if (|w_gnt) r_last <= w_sel;
    end

endmodule

// File: tb/tb_dram_arbiter.sv
// Directed bench for dram_arbiter with a per-port response scoreboard.
module tb_dram_arbiter;

    logic             clk = 1'b0;
    logic             rst = 1'b0;
    logic [1:0]       valid, we, rready;
    logic [1:0][31:0] addr, wdata;
    logic [1:0]       req_ready, rsp_valid, rsp_err;
    logic [1:0][31:0] rsp_rdata;
    logic [31:0]      mem_addr, mem_wdata;
    logic             mem_load, mem_store;
    logic [31:0]      ram_q;
    logic [31:0]      ram [16];
    logic             ram_init = 1'b1;

    logic [1:0]       fvalid, frready, f_req_ready, f_rsp_valid, f_rsp_err;
    logic [1:0][31:0] faddr, f_rsp_rdata;
    logic [31:0]      f_mem_addr, f_mem_wdata;
    logic             f_mem_load, f_mem_store;

    logic [1:0][31:0] exp_data;
    logic [1:0]       exp_err;
    logic [32:0]      q [2][$];
    int               total = 0;
    int               bad = 0;

    always #5 clk = ~clk;

    dram_arbiter #(.XLEN(32), .LINES(16), .FIXED_PRIO(0)) dut (
        .i_clk(clk), .i_rst(rst),
        .i_req_valid(valid), .o_req_ready(req_ready), .i_req_we(we),
        .i_req_addr(addr), .i_req_wdata(wdata),
        .o_rsp_valid(rsp_valid), .i_rsp_ready(rready),
        .o_rsp_rdata(rsp_rdata), .o_rsp_err(rsp_err),
        .o_mem_addr(mem_addr), .o_mem_load(mem_load), .o_mem_store(mem_store),
        .o_mem_wdata(mem_wdata), .i_mem_rdata(ram_q)
    );

    dram_arbiter #(.XLEN(32), .LINES(16), .FIXED_PRIO(1)) dut_fp (
        .i_clk(clk), .i_rst(rst),
        .i_req_valid(fvalid), .o_req_ready(f_req_ready), .i_req_we(2'b00),
        .i_req_addr(faddr), .i_req_wdata('0),
        .o_rsp_valid(f_rsp_valid), .i_rsp_ready(frready),
        .o_rsp_rdata(f_rsp_rdata), .o_rsp_err(f_rsp_err),
        .o_mem_addr(f_mem_addr), .o_mem_load(f_mem_load), .o_mem_store(f_mem_store),
        .o_mem_wdata(f_mem_wdata), .i_mem_rdata(32'h0)
    );

    // RAM model: 1-cycle read latency, word i preset to 0x1000+i, word 3 = 0x11
    always @(posedge clk) begin
        if (ram_init) begin
            for (int i = 0; i < 16; i++) ram[i] <= 32'h1000 + i;
            ram[3] <= 32'h11;
            ram_q  <= 32'h0;
        end else begin
            if (mem_store) ram[mem_addr[3:0]] <= mem_wdata;
            if (mem_load)  ram_q <= ram[mem_addr[3:0]];
        end
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    // Monitor: consume responses, then record loads accepted this cycle
    always @(negedge clk) begin
        logic [32:0] e;
        for (int p = 0; p < 2; p++) begin
            if (rsp_valid[p]) begin
                chk($sformatf("rsp%0d_expected", p), 32'(q[p].size() != 0), 32'd1);
                if (rready[p] && q[p].size() != 0) begin
                    e = q[p].pop_front();
                    chk($sformatf("rsp%0d_rdata", p), rsp_rdata[p], e[31:0]);
                    chk($sformatf("rsp%0d_err", p), 32'(rsp_err[p]), 32'(e[32]));
                end
            end
            if (!rst) q[p].delete();
            else if (valid[p] && req_ready[p] && !we[p])
                q[p].push_back({exp_err[p], exp_data[p]});
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog");
    end

    initial begin
        valid = '0; we = '0; rready = '0; addr = '0; wdata = '0;
        exp_data = '0; exp_err = '0;
        fvalid = '0; frready = '0; faddr = '0;
        repeat (2) @(posedge clk);
        #1;
        // reset: requests present but gated
        valid = 2'b11; addr[0] = 32'd5;
        @(negedge clk);
        chk("rst_req_ready", 32'(req_ready), 32'h0);
        chk("rst_mem_load", 32'(mem_load), 32'h0);
        chk("rst_mem_store", 32'(mem_store), 32'h0);
        chk("rst_mem_addr", mem_addr, 32'h0);
        chk("rst_rsp_valid", 32'(rsp_valid), 32'h0);
        chk("rst_rsp_rdata0", rsp_rdata[0], 32'h0);
        chk("rst_rsp_err", 32'(rsp_err), 32'h0);
        tick;
        ram_init = 1'b0; rst = 1'b1; valid = '0;

        // write then read addr 5
        valid = 2'b01; we = 2'b01; addr[0] = 32'd5; wdata[0] = 32'hDEADBEEF; rready = 2'b11;
        @(negedge clk);
        chk("wr_ready", 32'(req_ready), 32'h1);
        chk("wr_store", 32'(mem_store), 32'h1);
        chk("wr_addr", mem_addr, 32'd5);
        chk("wr_wdata", mem_wdata, 32'hDEADBEEF);
        chk("wr_load", 32'(mem_load), 32'h0);
        tick;
        we = 2'b00; exp_data[0] = 32'hDEADBEEF; exp_err[0] = 1'b0;
        @(negedge clk);
        chk("rd_load", 32'(mem_load), 32'h1);
        chk("rd_store_pulse", 32'(mem_store), 32'h0);
        chk("rd_rsp_early", 32'(rsp_valid), 32'h0);
        tick;
        valid = '0;
        @(negedge clk);
        chk("rd_rsp_n1", 32'(rsp_valid), 32'h1);
        chk("rd_idle_load", 32'(mem_load), 32'h0);
        tick;

        // contention from reset, round-robin
        rst = 1'b0;
        tick;
        rst = 1'b1;
        valid = 2'b11; we = 2'b00; addr[0] = 32'd1; addr[1] = 32'd2; rready = 2'b11;
        exp_data[0] = 32'h1001; exp_data[1] = 32'h1002; exp_err = 2'b00;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            chk($sformatf("rr_grant%0d", i), 32'(req_ready), (i % 2 == 0) ? 32'h1 : 32'h2);
            chk($sformatf("rr_load%0d", i), 32'(mem_load), 32'h1);
            chk($sformatf("rr_rsp%0d", i), 32'(rsp_valid),
                (i == 0) ? 32'h0 : ((i % 2 == 1) ? 32'h1 : 32'h2));
            tick;
        end
        valid = '0;
        @(negedge clk);
        chk("rr_last_rsp", 32'(rsp_valid), 32'h2);
        tick;

        // backpressure on port 0
        valid = 2'b01; addr[0] = 32'd3; rready = 2'b10; exp_data[0] = 32'h11;
        @(negedge clk);
        chk("bp_grant0", 32'(req_ready), 32'h1);
        tick;
        valid = 2'b11; addr[1] = 32'd2; exp_data[1] = 32'h1002;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            chk($sformatf("bp_ready%0d", k), 32'(req_ready), 32'h2);
            chk($sformatf("bp_valid0_%0d", k), 32'(rsp_valid[0]), 32'h1);
            chk($sformatf("bp_data0_%0d", k), rsp_rdata[0], 32'h11);
            tick;
        end
        rready = 2'b11;
        @(negedge clk);
        chk("bp_release_grant", 32'(req_ready), 32'h1);
        chk("bp_release_data", rsp_rdata[0], 32'h11);
        tick;
        valid = '0;
        @(negedge clk);
        chk("bp_next_rsp", 32'(rsp_valid), 32'h1);
        tick;

        // out of range load / store
        valid = 2'b01; we = 2'b00; addr[0] = 32'd16; exp_data[0] = 32'h0; exp_err[0] = 1'b1;
        @(negedge clk);
        chk("oor_ld_ready", 32'(req_ready), 32'h1);
        chk("oor_ld_noload", 32'(mem_load), 32'h0);
        tick;
        valid = '0;
        @(negedge clk);
        chk("oor_rsp_err", 32'(rsp_err[0]), 32'h1);
        chk("oor_noload2", 32'(mem_load), 32'h0);
        tick;
        valid = 2'b01; we = 2'b01; addr[0] = 32'd23; wdata[0] = 32'hBAD0BAD0;
        @(negedge clk);
        chk("oor_st_ready", 32'(req_ready), 32'h1);
        chk("oor_st_nostore", 32'(mem_store), 32'h0);
        tick;
        we = 2'b00; addr[0] = 32'd7; exp_data[0] = 32'h1007; exp_err[0] = 1'b0;
        @(negedge clk);
        chk("oor_ld7_load", 32'(mem_load), 32'h1);
        tick;
        valid = '0;
        @(negedge clk);
        chk("oor_ld7_rsp", 32'(rsp_valid), 32'h1);
        tick;

        // reset during an in-flight load
        valid = 2'b10; addr[1] = 32'd2; exp_data[1] = 32'h1002;
        @(negedge clk);
        chk("mr_grant1", 32'(req_ready), 32'h2);
        tick;
        rst = 1'b0; valid = 2'b11; rready = 2'b00; addr[0] = 32'd1; exp_data[0] = 32'h1001;
        @(negedge clk);
        chk("mr_inflight", 32'(rsp_valid), 32'h2);
        chk("mr_gated_ready", 32'(req_ready), 32'h0);
        chk("mr_gated_load", 32'(mem_load), 32'h0);
        tick;
        @(negedge clk);
        chk("mr_rsp_cleared", 32'(rsp_valid), 32'h0);
        chk("mr_load0", 32'(mem_load), 32'h0);
        chk("mr_store0", 32'(mem_store), 32'h0);
        chk("mr_addr0", mem_addr, 32'h0);
        tick;
        rst = 1'b1; rready = 2'b11;
        @(negedge clk);
        chk("mr_first_grant", 32'(req_ready), 32'h1);
        chk("mr_first_addr", mem_addr, 32'd1);
        tick;
        valid = '0;
        @(negedge clk);
        chk("mr_rsp", 32'(rsp_valid), 32'h1);
        tick;

        // fixed priority instance
        fvalid = 2'b11; frready = 2'b11; faddr[0] = 32'd1; faddr[1] = 32'd2;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            chk($sformatf("fp_grant%0d", i), 32'(f_req_ready), 32'h1);
            tick;
        end
        fvalid = 2'b10;
        @(negedge clk);
        chk("fp_port1", 32'(f_req_ready), 32'h2);
        tick;
        fvalid = '0;
        tick;

        chk("q0_drained", 32'(q[0].size()), 32'h0);
        chk("q1_drained", 32'(q[1].size()), 32'h0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
